// File: rtl/ps2_pkg.sv
// ============================================================================
// Module   : ps2_pkg
// Purpose  : Shared constants, state encoding and event layout for the PS/2
//            scan-code set 2 sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

package ps2_pkg;

    localparam logic [7:0] PS2_PFX_EXT  = 8'hE0;
    localparam logic [7:0] PS2_PFX_BRK  = 8'hF0;

    localparam logic [7:0] PS2_DIS_NUL  = 8'h00;
    localparam logic [7:0] PS2_DIS_BAT  = 8'hAA;
    localparam logic [7:0] PS2_DIS_ECHO = 8'hEE;
    localparam logic [7:0] PS2_DIS_ACK  = 8'hFA;
    localparam logic [7:0] PS2_DIS_FC   = 8'hFC;
    localparam logic [7:0] PS2_DIS_RSND = 8'hFE;
    localparam logic [7:0] PS2_DIS_ERR  = 8'hFF;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] S_E0   = 2'd1;
    localparam logic [1:0] S_F0   = 2'd2;
    localparam logic [1:0] S_E0F0 = 2'd3;

    // Event word is {ext, brk, code}
    localparam int PS2_EVT_W        = 10;
    localparam int PS2_EVT_CODE_LSB = 0;
    localparam int PS2_EVT_CODE_W   = 8;
    localparam int PS2_EVT_BRK_BIT  = 8;
    localparam int PS2_EVT_EXT_BIT  = 9;

    function automatic logic ps2_is_discard(input logic [7:0] b);
        return (b == PS2_DIS_NUL)  || (b == PS2_DIS_BAT)  || (b == PS2_DIS_ECHO) ||
               (b == PS2_DIS_ACK)  || (b == PS2_DIS_FC)   || (b == PS2_DIS_RSND) ||
               (b == PS2_DIS_ERR);
    endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_event_fifo.sv
// ============================================================================
// Module   : ps2_event_fifo
// Purpose  : Synchronous first-word-fall-through FIFO; head word is visible
//            combinationally while not empty. DEPTH must be a power of 2.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ps2_event_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 10
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign w_do_pop  = i_pop && !o_empty;
    // When full, a simultaneous pop frees the head slot that the push then reuses
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_data = o_empty ? '0 : r_mem[r_rd_ptr];

endmodule

`default_nettype wire

// File: rtl/ps2_scancode_ctrl.sv
// ============================================================================
// Module   : ps2_scancode_ctrl
// Purpose  : Scan-code set 2 prefix sequencer (E0/F0) feeding a valid/ready
//            key-event FIFO. Optional typematic repeat filter: PS2_REPEAT_FILTER_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ps2_scancode_ctrl
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                          CLK,
    input  logic                          RSTn,
    input  logic [7:0]                    PS2_Data,
    input  logic                          PS2_Done_Sig,
    output logic [7:0]                    Key_Code,
    output logic                          Key_Ext,
    output logic                          Key_Break,
    output logic                          Key_Valid,
    input  logic                          Key_Ready,
    output logic [$clog2(FIFO_DEPTH):0]   Fifo_Count,
    output logic                          Overflow,
    input  logic                          Ovf_Clr
);

    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] c_TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [1:0]           r_state;
    logic [1:0]           w_state_nxt;
    logic [TW-1:0]        r_tmo_cnt;
    logic                 w_is_final;
    logic                 w_evt_ext;
    logic                 w_evt_brk;
    logic [PS2_EVT_W-1:0] w_evt;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_fifo_full;
    logic                 w_fifo_empty;
    logic [PS2_EVT_W-1:0] w_head;
    logic                 r_overflow;

    // ---------------- state register ----------------
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_state_nxt = r_state;
        if (PS2_Done_Sig) begin
            if (PS2_Data == PS2_PFX_EXT) begin
                w_state_nxt = S_E0;
            end else if (PS2_Data == PS2_PFX_BRK) begin
                case (r_state)
                    IDLE:    w_state_nxt = S_F0;
                    S_E0:    w_state_nxt = S_E0F0;
                    default: w_state_nxt = r_state;
                endcase
            end else begin
                w_state_nxt = IDLE;
            end
        end else if ((r_state != IDLE) && (r_tmo_cnt >= c_TMO_LAST)) begin
            w_state_nxt = IDLE;
        end
    end

    // ---------------- output logic ----------------
    always_comb begin
        w_evt_ext  = (r_state == S_E0) || (r_state == S_E0F0);
        w_evt_brk  = (r_state == S_F0) || (r_state == S_E0F0);
        w_is_final = PS2_Done_Sig && (PS2_Data != PS2_PFX_EXT) &&
                     (PS2_Data != PS2_PFX_BRK) && !ps2_is_discard(PS2_Data);
        w_evt      = {w_evt_ext, w_evt_brk, PS2_Data};
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn)                    r_tmo_cnt <= '0;
        else if (PS2_Done_Sig)        r_tmo_cnt <= '0;
        else if (r_tmo_cnt != c_TMO_LAST) r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end

`ifdef PS2_REPEAT_FILTER_EN
    logic [8:0] r_last_make;
    logic       r_last_vld;
    logic       w_same;
    logic       w_repeat;

    assign w_same   = (r_last_make == {w_evt_ext, PS2_Data});
    assign w_repeat = !w_evt_brk && r_last_vld && w_same;
    assign w_push   = w_is_final && !w_repeat;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_last_make <= '0;
            r_last_vld  <= 1'b0;
        end else if (w_is_final) begin
            if (w_evt_brk) begin
                if (w_same) r_last_vld <= 1'b0;
            end else if (!w_repeat) begin
                r_last_make <= {w_evt_ext, PS2_Data};
                r_last_vld  <= 1'b1;
            end
        end
    end
`else
    assign w_push = w_is_final;
`endif

    ps2_event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (PS2_EVT_W)
    ) u_fifo (
        .clk     (CLK),
        .rst_n   (RSTn),
        .i_push  (w_push),
        .i_data  (w_evt),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (Fifo_Count)
    );

    assign Key_Valid = !w_fifo_empty;
    assign w_pop     = Key_Valid && Key_Ready;
    assign Key_Code  = w_head[PS2_EVT_CODE_LSB +: PS2_EVT_CODE_W];
    assign Key_Break = w_head[PS2_EVT_BRK_BIT];
    assign Key_Ext   = w_head[PS2_EVT_EXT_BIT];

    // A fresh overflow wins over a clear in the same cycle
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn)                                  r_overflow <= 1'b0;
        else if (w_push && w_fifo_full && !w_pop)   r_overflow <= 1'b1;
        else if (Ovf_Clr)                           r_overflow <= 1'b0;
    end

    assign Overflow = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_ps2_scancode_ctrl.sv
// ============================================================================
// Module   : tb_ps2_scancode_ctrl
// Purpose  : Directed + random self-checking bench for ps2_scancode_ctrl,
//            tracking prefixes and queued events with a flag/queue model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ps2_scancode_ctrl;

    localparam int DEPTH = 8;
    localparam int TMO   = 64;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] ps2_data;
    logic       ps2_done;
    logic [7:0] key_code;
    logic       key_ext;
    logic       key_break;
    logic       key_valid;
    logic       key_ready;
    logic [3:0] fifo_count;
    logic       overflow;
    logic       ovf_clr;

    always #5 clk = ~clk;

    ps2_scancode_ctrl #(
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .CLK          (clk),
        .RSTn         (rst_n),
        .PS2_Data     (ps2_data),
        .PS2_Done_Sig (ps2_done),
        .Key_Code     (key_code),
        .Key_Ext      (key_ext),
        .Key_Break    (key_break),
        .Key_Valid    (key_valid),
        .Key_Ready    (key_ready),
        .Fifo_Count   (fifo_count),
        .Overflow     (overflow),
        .Ovf_Clr      (ovf_clr)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [9:0] m_q[$];
    logic       m_ext, m_brk, m_ovf;
    logic [8:0] m_last_make;
    logic       m_last_vld;
    int         m_cyc, m_last_done;

`ifdef PS2_REPEAT_FILTER_EN
    localparam int EXP_N = 3;
    logic [9:0] exp_rep [5] = '{10'h01C, 10'h11C, 10'h01C, 10'h000, 10'h000};
`else
    localparam int EXP_N = 5;
    logic [9:0] exp_rep [5] = '{10'h01C, 10'h01C, 10'h01C, 10'h11C, 10'h01C};
`endif

    function automatic logic is_discard(input logic [7:0] b);
        return b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_ext = 1'b0; m_brk = 1'b0; m_ovf = 1'b0;
        m_last_make = '0; m_last_vld = 1'b0;
        m_cyc = 0; m_last_done = 0;
    endtask

    // Applies the byte rules to the cycle that just ended
    task automatic model_step(input logic d, input logic [7:0] b, input logic rdy, input logic clr);
        logic       pop, push, set;
        logic [9:0] e;
        pop = (m_q.size() != 0) && rdy;
        push = 1'b0; set = 1'b0; e = '0;
        if (d) begin
            if (m_cyc - m_last_done > TMO) begin m_ext = 1'b0; m_brk = 1'b0; end
            m_last_done = m_cyc;
            if (b == 8'hE0) begin
                m_ext = 1'b1; m_brk = 1'b0;
            end else if (b == 8'hF0) begin
                m_brk = 1'b1;
            end else if (is_discard(b)) begin
                m_ext = 1'b0; m_brk = 1'b0;
            end else begin
                e = {m_ext, m_brk, b};
                push = 1'b1;
`ifdef PS2_REPEAT_FILTER_EN
                if (!m_brk) begin
                    if (m_last_vld && m_last_make == {m_ext, b}) push = 1'b0;
                    else begin m_last_make = {m_ext, b}; m_last_vld = 1'b1; end
                end else if (m_last_make == {m_ext, b}) begin
                    m_last_vld = 1'b0;
                end
`endif
                m_ext = 1'b0; m_brk = 1'b0;
            end
        end
        if (pop) void'(m_q.pop_front());
        if (push) begin
            if (m_q.size() < DEPTH) m_q.push_back(e);
            else set = 1'b1;
        end
        if (set) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        m_cyc++;
    endtask

    task automatic check_all();
        chk("valid", key_valid, m_q.size() != 0);
        chk("count", fifo_count, m_q.size());
        chk("overflow", overflow, m_ovf);
        if (m_q.size() != 0) chk("head", {key_ext, key_break, key_code}, m_q[0]);
    endtask

    task automatic step(input logic d, input logic [7:0] b, input logic rdy, input logic clr);
        ps2_done = d; ps2_data = b; key_ready = rdy; ovf_clr = clr;
        @(posedge clk); #1;
        model_step(d, b, rdy, clr);
        ps2_done = 1'b0; ovf_clr = 1'b0;
        check_all();
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, rdy, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] pool [6] = '{8'h1C, 8'h1C, 8'h75, 8'hE1, 8'h32, 8'h5A};
        logic [7:0] dis  [7] = '{8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF};
        logic [7:0] b;
        int r;

        rst_n = 1'b0; ps2_data = '0; ps2_done = 1'b0; key_ready = 1'b0; ovf_clr = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", key_valid, 0);
        chk("rst_code", key_code, 0);
        chk("rst_ext", key_ext, 0);
        chk("rst_break", key_break, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_ovf", overflow, 0);
        rst_n = 1'b1;

        // single make, then pop
        step(1'b1, 8'h1C, 1'b0, 1'b0);
        chk("mk1c_valid", key_valid, 1);
        chk("mk1c_evt", {key_ext, key_break, key_code}, 10'h01C);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("mk1c_popped", key_valid, 0);

        // extended break
        step(1'b1, 8'hE0, 1'b0, 1'b0);
        chk("e0_noevt", key_valid, 0);
        step(1'b1, 8'hF0, 1'b0, 1'b0);
        chk("e0f0_noevt", key_valid, 0);
        step(1'b1, 8'h75, 1'b0, 1'b0);
        chk("e0f075_evt", {key_ext, key_break, key_code}, 10'h375);
        idle(2, 1'b1);

        // overflow with held consumer
        for (int i = 0; i < 9; i++) step(1'b1, 8'h10 + 8'(i), 1'b0, 1'b0);
        chk("full_count", fifo_count, 8);
        chk("full_ovf", overflow, 1);
        chk("full_head", {key_ext, key_break, key_code}, 10'h010);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("ovf_clr", overflow, 0);
        step(1'b1, 8'h20, 1'b1, 1'b0);
        chk("pushpop_full_count", fifo_count, 8);
        chk("pushpop_full_ovf", overflow, 0);
        step(1'b1, 8'h21, 1'b0, 1'b1);
        chk("ovf_beats_clr", overflow, 1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        idle(10, 1'b1);
        chk("drained", fifo_count, 0);

        // dangling prefix timeout, and its boundary
        step(1'b1, 8'hE0, 1'b0, 1'b0);
        idle(TMO, 1'b0);
        step(1'b1, 8'h1C, 1'b0, 1'b0);
        chk("tmo_drop", {key_ext, key_break, key_code}, 10'h01C);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b1, 8'hE0, 1'b0, 1'b0);
        idle(TMO - 1, 1'b0);
        step(1'b1, 8'h1C, 1'b0, 1'b0);
        chk("tmo_keep", {key_ext, key_break, key_code}, 10'h21C);
        step(1'b0, 8'h00, 1'b1, 1'b0);

        // discard codes
        step(1'b1, 8'hFA, 1'b0, 1'b0);
        step(1'b1, 8'hAA, 1'b0, 1'b0);
        step(1'b1, 8'hFE, 1'b0, 1'b0);
        chk("discard_noevt", key_valid, 0);
        step(1'b1, 8'hF0, 1'b0, 1'b0);
        step(1'b1, 8'hAA, 1'b0, 1'b0);
        step(1'b1, 8'h1C, 1'b0, 1'b0);
        chk("f0aa1c_evt", {key_ext, key_break, key_code}, 10'h01C);
        step(1'b0, 8'h00, 1'b1, 1'b0);

        // typematic repeats
        step(1'b1, 8'h32, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b1, 8'h1C, 1'b0, 1'b0);
        step(1'b1, 8'h1C, 1'b0, 1'b0);
        step(1'b1, 8'h1C, 1'b0, 1'b0);
        step(1'b1, 8'hF0, 1'b0, 1'b0);
        step(1'b1, 8'h1C, 1'b0, 1'b0);
        step(1'b1, 8'h1C, 1'b0, 1'b0);
        chk("rep_count", fifo_count, EXP_N);
        for (int i = 0; i < EXP_N; i++) begin
            chk("rep_evt", {key_ext, key_break, key_code}, exp_rep[i]);
            step(1'b0, 8'h00, 1'b1, 1'b0);
        end
        chk("rep_empty", key_valid, 0);

        // random traffic
        for (int it = 0; it < 1500; it++) begin
            r = $urandom_range(0, 9);
            if (r < 2)      b = 8'hE0;
            else if (r < 4) b = 8'hF0;
            else if (r < 5) b = dis[$urandom_range(0, 6)];
            else            b = pool[$urandom_range(0, 5)];
            step(1'b1, b, ($urandom_range(0, 9) < 6), ($urandom_range(0, 19) == 0));
            if ($urandom_range(0, 19) == 0)
                idle($urandom_range(TMO - 2, TMO + 2), ($urandom_range(0, 1) == 1));
            else if ($urandom_range(0, 3) == 0)
                idle($urandom_range(1, 3), ($urandom_range(0, 1) == 1));
        end

        // reset in mid-sequence
        step(1'b1, 8'h1C, 1'b0, 1'b0);
        step(1'b1, 8'h32, 1'b0, 1'b0);
        step(1'b1, 8'hE0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #2;
        chk("async_rst_valid", key_valid, 0);
        chk("async_rst_count", fifo_count, 0);
        chk("async_rst_ovf", overflow, 0);
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        step(1'b1, 8'h1C, 1'b0, 1'b0);
        chk("post_rst_evt", {key_ext, key_break, key_code}, 10'h01C);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
